tile_map_writer: RTL and testbench

- Owns the tile-map RAM that stores the 4-bit sprite code of every 32×32 screen tile, packed 8 tiles per 32-bit word.
- Game logic writes single tiles through a valid/ready port. The block performs a read-modify-write of the packed word.
- The pixel pipeline (snake_gen) reads whole words through a 1-cycle read port driven by its `tile_x`/`tile_y`.
- An optional sweep fills the whole map with one code.

---
 rtl/snake_pkg.sv | 29 ++
 rtl/tile_map_ram.sv | 31 +++
 rtl/tile_map_writer.sv | 155 +++++++++++++++
 tb/tb_tile_map_writer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared constants, FSM state type and nibble-merge helper for the tile map.
// The CLR state exists only when TILE_MAP_CLEAR_EN is defined.
package snake_pkg;
  localparam int unsigned TILE_BITS         = 4;
  localparam int unsigned TILES_PER_WORD    = 8;
  localparam int unsigned WORD_BITS         = 32;
  localparam int unsigned DEF_GRID_ROWS     = 15;
  localparam int unsigned DEF_WORDS_PER_ROW = 3;

`ifdef TILE_MAP_CLEAR_EN
  typedef enum logic [1:0] {IDLE, RD, WR, CLR} map_state_t;
`else
  typedef enum logic [1:0] {IDLE, RD, WR} map_state_t;
`endif

  // Replace nibble idx of word with code, leaving the other seven intact.
  function automatic logic [WORD_BITS-1:0] merge_tile(
    input logic [WORD_BITS-1:0] word,
    input logic [2:0]           idx,
    input logic [TILE_BITS-1:0] code
  );
    logic [WORD_BITS-1:0] w;
    w = word;
    for (int unsigned i = 0; i < TILES_PER_WORD; i++) begin
      if (idx == 3'(i)) w[i*TILE_BITS +: TILE_BITS] = code;
    end
    return w;
  endfunction
endpackage

// File: rtl/tile_map_ram.sv
// Simple dual-port DEPTHx32 RAM: port A read-only, port B read/write.
// Both ports have a registered 1-cycle read; read-first, no reset.
module tile_map_ram
  import snake_pkg::*;
#(
  parameter int unsigned DEPTH = 45,
  parameter int unsigned AW    = 6
) (
  input  logic                 clk,
  input  logic                 en_a,
  input  logic [AW-1:0]        addr_a,
  output logic [WORD_BITS-1:0] q_a,
  input  logic                 en_b,
  input  logic                 we_b,
  input  logic [AW-1:0]        addr_b,
  input  logic [WORD_BITS-1:0] d_b,
  output logic [WORD_BITS-1:0] q_b
);
  logic [WORD_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en_a) q_a <= mem[addr_a];
  end

  always_ff @(posedge clk) begin
    if (en_b) begin
      q_b <= mem[addr_b];
      if (we_b) mem[addr_b] <= d_b;
    end
  end
endmodule

// File: rtl/tile_map_writer.sv
// Tile-map owner: registered display read port plus a read-modify-write
// single-tile writer. Optional full-map fill sweep under TILE_MAP_CLEAR_EN.
module tile_map_writer
  import snake_pkg::*;
#(
  parameter int unsigned GRID_ROWS     = DEF_GRID_ROWS,
  parameter int unsigned WORDS_PER_ROW = DEF_WORDS_PER_ROW,
  parameter int unsigned DEPTH         = GRID_ROWS * WORDS_PER_ROW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  tile_x,
  input  logic [5:0]  tile_y,
  output logic [31:0] sprite_addr,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_tile_x,
  input  logic [5:0]  wr_tile_y,
  input  logic [3:0]  wr_code,
`ifdef TILE_MAP_CLEAR_EN
  input  logic        clr_req,
  input  logic [3:0]  clr_code,
`endif
  output logic        busy
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic in_range(input logic [2:0] word_x, input logic [5:0] y);
    return (32'(y) < GRID_ROWS) && (32'(word_x) < WORDS_PER_ROW);
  endfunction

  function automatic logic [AW-1:0] word_addr(input logic [2:0] word_x, input logic [5:0] y);
    logic [31:0] a;
    a = 32'(y) * WORDS_PER_ROW + 32'(word_x);
    return a[AW-1:0];
  endfunction

  map_state_t           state, state_n;
  logic [AW-1:0]        op_addr;
  logic [2:0]           op_idx;
  logic [TILE_BITS-1:0] op_code;
  logic                 wr_take;
  logic                 rd_en_a, rd_hit;
  logic [WORD_BITS-1:0] q_a, q_b, d_b;
  logic                 en_b, we_b;
  logic [AW-1:0]        addr_b;
  logic                 unused_low;

  assign unused_low = ^tile_x[2:0];

`ifdef TILE_MAP_CLEAR_EN
  logic [AW-1:0]        clr_cnt;
  logic [TILE_BITS-1:0] clr_fill;
  logic                 clr_take;
`endif

  // Out-of-range display reads skip the RAM and force a zero output.
  assign rd_en_a     = in_range(tile_x[5:3], tile_y);
  assign sprite_addr = rd_hit ? q_a : '0;

  assign wr_ready = (state == IDLE) && rst_n;
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    wr_take = 1'b0;
    en_b    = 1'b0;
    we_b    = 1'b0;
    addr_b  = op_addr;
    d_b     = merge_tile(q_b, op_idx, op_code);
`ifdef TILE_MAP_CLEAR_EN
    clr_take = 1'b0;
`endif
    unique case (state)
      IDLE: begin
`ifdef TILE_MAP_CLEAR_EN
        if (clr_req) begin
          clr_take = 1'b1;
          state_n  = CLR;
        end else
`endif
        if (wr_valid && in_range(wr_tile_x[5:3], wr_tile_y)) begin
          wr_take = 1'b1;
          state_n = RD;
        end
      end
      RD: begin
        en_b    = 1'b1;
        state_n = WR;
      end
      WR: begin
        en_b    = 1'b1;
        we_b    = 1'b1;
        state_n = IDLE;
      end
`ifdef TILE_MAP_CLEAR_EN
      CLR: begin
        en_b   = 1'b1;
        we_b   = 1'b1;
        addr_b = clr_cnt;
        d_b    = {TILES_PER_WORD{clr_fill}};
        if (clr_cnt == AW'(DEPTH - 1)) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_hit  <= 1'b0;
      op_addr <= '0;
      op_idx  <= '0;
      op_code <= '0;
    end else begin
      state  <= state_n;
      rd_hit <= rd_en_a;
      if (wr_take) begin
        op_addr <= word_addr(wr_tile_x[5:3], wr_tile_y);
        op_idx  <= wr_tile_x[2:0];
        op_code <= wr_code;
      end
    end
  end

`ifdef TILE_MAP_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt  <= '0;
      clr_fill <= '0;
    end else if (clr_take) begin
      clr_cnt  <= '0;
      clr_fill <= clr_code;
    end else if (state == CLR) begin
      clr_cnt <= clr_cnt + 1'b1;
    end
  end
`endif

  tile_map_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk    (clk),
    .en_a   (rd_en_a),
    .addr_a (word_addr(tile_x[5:3], tile_y)),
    .q_a    (q_a),
    .en_b   (en_b),
    .we_b   (we_b),
    .addr_b (addr_b),
    .d_b    (d_b),
    .q_b    (q_b)
  );
endmodule

// File: tb/tb_tile_map_writer.sv
// Directed and randomized checks of tile_map_writer against a per-tile map model.
module tb_tile_map_writer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  tile_x, tile_y, wr_tile_x, wr_tile_y;
  logic [31:0] sprite_addr;
  logic        wr_valid, wr_ready, busy;
  logic [3:0]  wr_code;
`ifdef TILE_MAP_CLEAR_EN
  logic        clr_req;
  logic [3:0]  clr_code;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Model: one sprite code per visible tile slot (15 rows x 3 words x 8 tiles).
  logic [3:0] tiles [15][24];

  always #5 clk = ~clk;

  tile_map_writer #(
    .GRID_ROWS     (15),
    .WORDS_PER_ROW (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tile_x      (tile_x),
    .tile_y      (tile_y),
    .sprite_addr (sprite_addr),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_tile_x   (wr_tile_x),
    .wr_tile_y   (wr_tile_y),
    .wr_code     (wr_code),
`ifdef TILE_MAP_CLEAR_EN
    .clr_req     (clr_req),
    .clr_code    (clr_code),
`endif
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit vis(input int x, input int y);
    return (y < 15) && (x < 24);
  endfunction

  function automatic logic [31:0] exp_word(input int x, input int y);
    logic [31:0] w;
    int base;
    w = '0;
    if (!vis(x, y)) return w;
    base = (x / 8) * 8;
    for (int k = 0; k < 8; k++) w[4*k +: 4] = tiles[y][base + k];
    return w;
  endfunction

  task automatic do_write(input int x, input int y, input logic [3:0] c);
    chk("ready_before_wr", 32'(wr_ready), 32'd1);
    wr_valid  = 1'b1;
    wr_tile_x = 6'(x);
    wr_tile_y = 6'(y);
    wr_code   = c;
    tick();
    wr_valid = 1'b0;
    if (vis(x, y)) begin
      chk("busy_rd", 32'(busy), 32'd1);
      tick();
      chk("busy_wr", 32'(busy), 32'd1);
      tick();
      chk("ready_after_wr", 32'(wr_ready), 32'd1);
      tiles[y][x] = c;
    end else begin
      chk("drop_busy", 32'(busy), 32'd0);
      chk("drop_ready", 32'(wr_ready), 32'd1);
    end
  endtask

  task automatic read_chk(input int x, input int y, input string tag);
    tile_x = 6'(x);
    tile_y = 6'(y);
    tick();
    chk(tag, sprite_addr, exp_word(x, y));
  endtask

  task automatic check_all();
    for (int y = 0; y < 15; y++)
      for (int w = 0; w < 3; w++) read_chk(w * 8, y, "map_scan");
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_tile_x = '0; wr_tile_y = '0; wr_code = '0;
    tile_x = '0; tile_y = '0;
`ifdef TILE_MAP_CLEAR_EN
    clr_req = 1'b0; clr_code = '0;
`endif
    #3;
    chk("rst_sprite", sprite_addr, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd0);
    #20 rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(wr_ready), 32'd1);

    // Establish a known all-zero map.
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 24; x++) do_write(x, y, 4'h0);

    // Write (5,2)=A; reads sampled at T+1/T+2 see old word, T+3 sees new.
    wr_valid = 1'b1; wr_tile_x = 6'd5; wr_tile_y = 6'd2; wr_code = 4'hA;
    tick();
    wr_valid = 1'b0; tile_x = 6'd0; tile_y = 6'd2;
    tick();
    chk("t1_old", sprite_addr, 32'h0);
    tick();
    chk("t2_old", sprite_addr, 32'h0);
    tick();
    chk("t3_new", sprite_addr, 32'h00A00000);
    tiles[2][5] = 4'hA;

    // Back-to-back writes with wr_valid held.
    wr_valid = 1'b1; wr_tile_x = 6'd16; wr_tile_y = 6'd14; wr_code = 4'h3;
    tick();
    wr_tile_x = 6'd17; wr_code = 4'hC;
    chk("b2b_a_rdy0", 32'(wr_ready), 32'd0);
    tick();
    chk("b2b_a_rdy1", 32'(wr_ready), 32'd0);
    tick();
    chk("b2b_a_rdy2", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("b2b_b_rdy0", 32'(wr_ready), 32'd0);
    tick();
    chk("b2b_b_rdy1", 32'(wr_ready), 32'd0);
    tick();
    chk("b2b_b_rdy2", 32'(wr_ready), 32'd1);
    tiles[14][16] = 4'h3;
    tiles[14][17] = 4'hC;
    read_chk(16, 14, "b2b_word44");
    chk("b2b_word44_const", sprite_addr, 32'h000000C3);

    // Out-of-range writes are accepted and dropped.
    do_write(24, 0, 4'h5);
    do_write(0, 15, 4'h9);
    read_chk(0, 15, "oor_read_y15");
    chk("oor_read_const", sprite_addr, 32'h0);
    read_chk(24, 0, "oor_read_x24");
    read_chk(0, 1, "oor_alias_row1");

    // Display read of (3,4) in the same cycle WR writes it.
    wr_valid = 1'b1; wr_tile_x = 6'd3; wr_tile_y = 6'd4; wr_code = 4'h6;
    tick();
    wr_valid = 1'b0; tile_x = 6'd0; tile_y = 6'd0;
    tick();
    tile_x = 6'd3; tile_y = 6'd4;
    tick();
    chk("rf_old", sprite_addr, 32'h0);
    tick();
    chk("rf_new", sprite_addr, 32'h00006000);
    tiles[4][3] = 4'h6;

    // Reset during RD abandons the pending write.
    do_write(2, 1, 4'h5);
    read_chk(1, 1, "pre_rst_word");
    wr_valid = 1'b1; wr_tile_x = 6'd1; wr_tile_y = 6'd1; wr_code = 4'hF;
    tick();
    wr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_sprite", sprite_addr, 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(wr_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("midrst_ready_after", 32'(wr_ready), 32'd1);
    read_chk(1, 1, "midrst_word_kept");
    chk("midrst_word_const", sprite_addr, 32'h00000500);

`ifdef TILE_MAP_CLEAR_EN
    // Clear wins over a simultaneous write; the write follows the sweep.
    clr_req = 1'b1; clr_code = 4'h7;
    wr_valid = 1'b1; wr_tile_x = 6'd4; wr_tile_y = 6'd6; wr_code = 4'h9;
    tick();
    clr_req = 1'b0;
    chk("clr_busy_0", 32'(busy), 32'd1);
    for (int i = 1; i < 45; i++) begin
      tick();
      chk("clr_busy", 32'(busy), 32'd1);
    end
    tick();
    chk("clr_done_busy", 32'(busy), 32'd0);
    chk("clr_done_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    chk("clr_then_wr", 32'(busy), 32'd1);
    tick();
    tick();
    for (int y = 0; y < 15; y++)
      for (int x = 0; x < 24; x++) tiles[y][x] = 4'h7;
    tiles[6][4] = 4'h9;
    read_chk(0, 0, "clr_word0");
    chk("clr_word0_const", sprite_addr, 32'h77777777);
    check_all();
`endif

    // Randomized writes (some out of range) interleaved with reads.
    for (int i = 0; i < 150; i++) begin
      do_write(int'($urandom_range(0, 31)), int'($urandom_range(0, 16)), 4'($urandom));
      read_chk(int'($urandom_range(0, 31)), int'($urandom_range(0, 16)), "rand_read");
    end
    check_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
